// File: rtl/spi_quad_rx.sv
// Four-lane serial frame receiver: captures MSB-first frames under an active-low strobe,
// strips the padding and hands the four payload words to a valid/ready consumer.
module spi_quad_rx #(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned FRAME_W = 16,
    parameter int unsigned PAD_LSB = 2
) (
    input  logic              rst_n,
    input  logic              clk,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_data_0a,
    input  logic              i_spi_data_0b,
    input  logic              i_spi_data_1a,
    input  logic              i_spi_data_1b,
    output logic [DATA_W-1:0] o_data_0a,
    output logic [DATA_W-1:0] o_data_0b,
    output logic [DATA_W-1:0] o_data_1a,
    output logic [DATA_W-1:0] o_data_1b,
    output logic              o_vld,
    input  logic              i_rdy,
    input  logic              i_clr,
    output logic              o_frame_err,
    output logic              o_fmt_err,
    output logic              o_ovf
);

    localparam int unsigned CntW = $clog2(FRAME_W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_W - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FRAME_W);
    // Bits of a full frame word that carry payload; everything else must be zero.
    localparam logic [FRAME_W-1:0] FieldMask =
        ((FRAME_W'(1) << DATA_W) - FRAME_W'(1)) << PAD_LSB;

    // StArm: after reset, wait for a high strobe sample so a frame already in flight is ignored.
    typedef enum logic [0:0] {
        StArm,
        StRun
    } state_e;

    state_e                          state_q;
    logic   [CntW-1:0]               cnt_q;
    // The oldest frame bit is never needed: the word is completed with the live lane input.
    logic   [3:0][FRAME_W-2:0]       shift_q;
    logic   [3:0][DATA_W-1:0]        data_q;
    logic                            vld_q;
    logic                            frame_err_q;
    logic                            fmt_err_q;
    logic                            ovf_q;

    logic   [3:0]                    lane_in;
    logic   [3:0][FRAME_W-1:0]       word;
    logic   [3:0][DATA_W-1:0]        payload;
    logic                            pad_nz;
    logic                            sample;
    logic                            complete;
    logic                            short_frame;
    logic                            long_frame;
    logic                            load;
    logic                            drop;

    always_comb begin
        lane_in = {i_spi_data_1b, i_spi_data_1a, i_spi_data_0b, i_spi_data_0a};
        word    = '0;
        payload = '0;
        pad_nz  = 1'b0;
        for (int l = 0; l < 4; l++) begin
            word[l]    = {shift_q[l], lane_in[l]};
            payload[l] = word[l][PAD_LSB+DATA_W-1:PAD_LSB];
            pad_nz     = pad_nz | (|(word[l] & ~FieldMask));
        end
    end

    always_comb begin
        sample      = (state_q == StRun) && !i_spi_cs_n && (cnt_q != CntFull);
        complete    = sample && (cnt_q == CntLast);
        short_frame = (state_q == StRun) && i_spi_cs_n && (cnt_q != '0) && (cnt_q != CntFull);
        long_frame  = (state_q == StRun) && !i_spi_cs_n && (cnt_q == CntFull);
        load        = complete && (!vld_q || i_rdy);
        drop        = complete && vld_q && !i_rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StArm;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            frame_err_q <= 1'b0;
            fmt_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StArm: begin
                    cnt_q <= '0;
                    if (i_spi_cs_n) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (i_spi_cs_n) begin
                        cnt_q <= '0;
                    end else if (sample) begin
                        cnt_q <= cnt_q + CntW'(1);
                        for (int l = 0; l < 4; l++) begin
                            shift_q[l] <= word[l][FRAME_W-2:0];
                        end
                    end
                end
                default: state_q <= StArm;
            endcase

            if (load) begin
                data_q <= payload;
                vld_q  <= 1'b1;
            end else if (vld_q && i_rdy) begin
                vld_q <= 1'b0;
            end

            // A set condition on the same edge beats the clear.
            frame_err_q <= (frame_err_q && !i_clr) || short_frame || long_frame;
            fmt_err_q   <= (fmt_err_q && !i_clr) || (complete && pad_nz);
            ovf_q       <= (ovf_q && !i_clr) || drop;
        end
    end

    assign o_data_0a   = data_q[0];
    assign o_data_0b   = data_q[1];
    assign o_data_1a   = data_q[2];
    assign o_data_1b   = data_q[3];
    assign o_vld       = vld_q;
    assign o_frame_err = frame_err_q;
    assign o_fmt_err   = fmt_err_q;
    assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_spi_quad_rx.sv
// Directed-plus-random bench for spi_quad_rx against a frame-level reference model.
module tb_spi_quad_rx;

    logic       rst_n = 1'b1;
    logic       clk = 1'b0;
    logic       cs_n = 1'b1;
    logic [3:0] lanes = '0;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;
    logic [9:0] d0a, d0b, d1a, d1b;
    logic       vld, ferr, fmterr, ovf;

    int tests = 0;
    int fails = 0;

    spi_quad_rx dut (
        .rst_n        (rst_n),
        .clk          (clk),
        .i_spi_cs_n   (cs_n),
        .i_spi_data_0a(lanes[0]),
        .i_spi_data_0b(lanes[1]),
        .i_spi_data_1a(lanes[2]),
        .i_spi_data_1b(lanes[3]),
        .o_data_0a    (d0a),
        .o_data_0b    (d0b),
        .o_data_1a    (d1a),
        .o_data_1b    (d1b),
        .o_vld        (vld),
        .i_rdy        (rdy),
        .i_clr        (clr),
        .o_frame_err  (ferr),
        .o_fmt_err    (fmterr),
        .o_ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: frame bits collected per lane, delivered payloads and flags.
    bit         m_armed;
    int         m_nbits;
    logic [15:0] m_cur [4];
    logic [9:0] m_data [4];
    bit         m_vld, m_ferr, m_fmt, m_ovf;
    int         rdy_mode;  // 0 low, 1 high, 2 random, 3 high only on the last sampled bit

    task automatic model_reset();
        m_armed = 0;
        m_nbits = 0;
        for (int l = 0; l < 4; l++) begin
            m_cur[l]  = '0;
            m_data[l] = '0;
        end
        m_vld = 0; m_ferr = 0; m_fmt = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input logic c, input logic [3:0] b, input logic r,
                              input logic cl);
        bit set_f = 0, set_fmt = 0, set_ovf = 0, done = 0;
        logic [9:0] pay [4];
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_armed) begin
            if (c) m_armed = 1;
        end else if (c) begin
            if (m_nbits > 0 && m_nbits < 16) set_f = 1;
            m_nbits = 0;
        end else if (m_nbits < 16) begin
            for (int l = 0; l < 4; l++) m_cur[l] = {m_cur[l][14:0], b[l]};
            m_nbits++;
            done = (m_nbits == 16);
        end else begin
            set_f = 1;
        end
        if (done) begin
            for (int l = 0; l < 4; l++) begin
                pay[l] = 10'((m_cur[l] >> 2) & 16'h03FF);
                if ((m_cur[l] & 16'hF003) != 0) set_fmt = 1;
            end
            if (!m_vld || r) begin
                for (int l = 0; l < 4; l++) m_data[l] = pay[l];
                m_vld = 1;
            end else begin
                set_ovf = 1;
            end
        end else if (m_vld && r) begin
            m_vld = 0;
        end
        if (cl) begin
            m_ferr = 0; m_fmt = 0; m_ovf = 0;
        end
        m_ferr = m_ferr | set_f;
        m_fmt  = m_fmt | set_fmt;
        m_ovf  = m_ovf | set_ovf;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("vld", 16'(vld), 16'(m_vld));
        chk("data_0a", 16'(d0a), 16'(m_data[0]));
        chk("data_0b", 16'(d0b), 16'(m_data[1]));
        chk("data_1a", 16'(d1a), 16'(m_data[2]));
        chk("data_1b", 16'(d1b), 16'(m_data[3]));
        chk("frame_err", 16'(ferr), 16'(m_ferr));
        chk("fmt_err", 16'(fmterr), 16'(m_fmt));
        chk("ovf", 16'(ovf), 16'(m_ovf));
    endtask

    // Drive one clock of inputs, update the model at the edge, check on the falling edge.
    task automatic cycle(input logic c, input logic [3:0] b, input logic r, input logic cl);
        cs_n = c; lanes = b; rdy = r; clr = cl;
        @(posedge clk);
        model_edge(c, b, r, cl);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input logic r, input logic cl);
        for (int i = 0; i < n; i++) cycle(1'b1, 4'b0, r, cl);
    endtask

    task automatic frame(input logic [3:0][15:0] w, input int len);
        logic [3:0] b;
        logic       r;
        for (int i = 0; i < len; i++) begin
            for (int l = 0; l < 4; l++) b[l] = (i < 16) ? w[l][15-i] : 1'($urandom);
            case (rdy_mode)
                0: r = 1'b0;
                1: r = 1'b1;
                2: r = 1'($urandom);
                default: r = (i == 15);
            endcase
            cycle(1'b0, b, r, 1'b0);
        end
    endtask

    logic [3:0][15:0] fa, fb, fc, fw;
    logic [9:0]       p;

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        idle(2, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        idle(1, 1'b0, 1'b0);

        // Single frame
        rdy_mode = 1;
        fw[0] = 16'hFFC; fw[1] = 16'h000; fw[2] = 16'h554; fw[3] = 16'hAA8;
        frame(fw, 16);
        chk("single_vld_latency", 16'(vld), 16'h1);
        chk("single_0a", 16'(d0a), 16'h3FF);
        chk("single_1b", 16'(d1b), 16'h2AA);
        cs_n = 1'b1;
        idle(1, 1'b1, 1'b0);
        chk("single_vld_one_cycle", 16'(vld), 16'h0);

        // Backpressure: second frame dropped
        rdy_mode = 0;
        for (int l = 0; l < 4; l++) begin
            fa[l] = 16'(($urandom & 10'h3FF) << 2);
            fb[l] = 16'(($urandom & 10'h3FF) << 2);
            fc[l] = 16'(($urandom & 10'h3FF) << 2);
        end
        frame(fa, 16);
        idle(1, 1'b0, 1'b0);
        frame(fb, 16);
        chk("bp_ovf", 16'(ovf), 16'h1);
        chk("bp_hold_0a", 16'(d0a), 16'(fa[0] >> 2));

        // Accept on the completion edge
        idle(1, 1'b0, 1'b1);
        rdy_mode = 3;
        frame(fc, 16);
        chk("edge_vld", 16'(vld), 16'h1);
        chk("edge_data_1a", 16'(d1a), 16'(fc[2] >> 2));
        chk("edge_ovf", 16'(ovf), 16'h0);
        idle(1, 1'b1, 1'b0);

        // Short frame, then overlong frame
        rdy_mode = 1;
        frame(16'h0, 9);
        idle(1, 1'b1, 1'b0);
        chk("short_ferr", 16'(ferr), 16'h1);
        chk("short_no_vld", 16'(vld), 16'h0);
        idle(1, 1'b1, 1'b1);
        frame(fa, 20);
        chk("long_ferr", 16'(ferr), 16'h1);
        idle(2, 1'b1, 1'b0);

        // Format error on lane 1b
        fw[0] = 16'h0; fw[1] = 16'h0; fw[2] = 16'h0; fw[3] = 16'h8004;
        frame(fw, 16);
        chk("fmt_flag", 16'(fmterr), 16'h1);
        chk("fmt_1b", 16'(d1b), 16'h001);
        idle(2, 1'b1, 1'b1);

        // Random frames, gaps, backpressure and occasional pad faults
        rdy_mode = 2;
        for (int n = 0; n < 24; n++) begin
            for (int l = 0; l < 4; l++) begin
                p = 10'($urandom);
                fw[l] = 16'({p, 2'b00});
                if ($urandom_range(0, 7) == 0) fw[l][$urandom_range(12, 15)] = 1'b1;
                if ($urandom_range(0, 9) == 0) fw[l][$urandom_range(0, 1)] = 1'b1;
            end
            frame(fw, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : 16);
            idle($urandom_range(1, 3), 1'($urandom), ($urandom_range(0, 5) == 0));
        end

        // Reset in the middle of a frame, released with the strobe still low
        rdy_mode = 1;
        frame(fa, 7);
        @(negedge clk) rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'hF, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'hF, 1'b1, 1'b0);
        chk("rst_no_ferr", 16'(ferr), 16'h0);
        idle(1, 1'b1, 1'b0);
        frame(fb, 16);
        chk("rst_frame_vld", 16'(vld), 16'h1);
        chk("rst_frame_0b", 16'(d0b), 16'(fb[1] >> 2));
        idle(2, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
